// File: rtl/chainreset_seq_pkg.sv
// Shared definitions for the reset-chain sequencer: state encoding, default
// timing parameters and a ceiling-log2 helper for index-width checking.
package chainreset_seq_pkg;

    localparam int unsigned ST_W = 3;

    localparam logic [ST_W-1:0] ST_IDLE    = 3'd0;
    localparam logic [ST_W-1:0] ST_ARM     = 3'd1;
    localparam logic [ST_W-1:0] ST_LAUNCH  = 3'd2;
    localparam logic [ST_W-1:0] ST_WAIT    = 3'd3;
    localparam logic [ST_W-1:0] ST_BACKOFF = 3'd4;
    localparam logic [ST_W-1:0] ST_SUCCESS = 3'd5;
    localparam logic [ST_W-1:0] ST_FAIL    = 3'd6;

    typedef enum logic [ST_W-1:0] {
        S_IDLE    = ST_IDLE,
        S_ARM     = ST_ARM,
        S_LAUNCH  = ST_LAUNCH,
        S_WAIT    = ST_WAIT,
        S_BACKOFF = ST_BACKOFF,
        S_SUCCESS = ST_SUCCESS,
        S_FAIL    = ST_FAIL
    } state_t;

    localparam int unsigned DEF_ARMLEN = 4;
    localparam int unsigned DEF_BLANK  = 2;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v << 1;
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/chainreset_seq_prio_hi_zero.sv
// Combinational finder: highest index i >= lo with vec[i] == 0 (lo if none).
module prio_hi_zero
    import chainreset_seq_pkg::*;
#(
    parameter int unsigned N = 4,
    parameter int unsigned W = 2
) (
    input  logic [N-1:0] vec,
    input  logic [W-1:0] lo,
    output logic [W-1:0] idx_c
);

    // Ascending scan so the last qualifying hit (highest index) wins.
    always_comb begin
        idx_c = lo;
        for (int i = 0; i < N; i++) begin
            if (!vec[i] && (i >= int'(lo))) begin
                idx_c = W'(i);
            end
        end
    end

endmodule

// File: rtl/chainreset_seq.sv
// Reset-chain sequencer: arms, launches and monitors the chain with retry/back-off.
// Optional auto-restart from SUCCESS on link loss: CHAINRESET_SEQ_AUTORESTART_EN.
module chainreset_seq
    import chainreset_seq_pkg::*;
#(
    parameter int unsigned NSTEP  = 4,
    parameter int unsigned SW     = 2,
    parameter int unsigned ARMLEN = DEF_ARMLEN,
    parameter int unsigned BLANK  = DEF_BLANK
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             abort,
    input  logic [SW-1:0]    stopstep,
    input  logic [7:0]       maxretry,
    input  logic [15:0]      retrydelay,
    input  logic [31:0]      gtimeout,
    input  logic             linkdown,
    output logic [NSTEP-1:0] chain_resetin,
    input  logic [NSTEP-1:0] chain_done,
    input  logic [NSTEP-1:0] chain_error,
    output logic             busy,
    output logic             success,
    output logic             fail,
    output logic             donepulse,
    output logic [7:0]       retrycnt,
    output logic [SW-1:0]    failstep
);

    if ((clog2(NSTEP) > SW) || (ARMLEN < 2)) begin : g_param_check
        $error("chainreset_seq: SW too narrow for NSTEP or ARMLEN below 2");
    end

    state_t            state, state_d;
    logic [31:0]       cnt, cnt_d, cnt_inc;
    logic [NSTEP-1:0]  resetin_d, launch_mask;
    logic              busy_d, success_d, fail_d, donepulse_d;
    logic [7:0]        retrycnt_d;
    logic [SW-1:0]     failstep_d, sel, fz_idx;
    logic              done_hit, err_hit, timeout_hit, backoff_end, restart;

    assign sel         = (stopstep > SW'(NSTEP - 1)) ? SW'(NSTEP - 1) : stopstep;
    assign done_hit    = chain_done[sel];
    assign err_hit     = |(chain_error & launch_mask);
    assign timeout_hit = (gtimeout != 32'd0) && (cnt == gtimeout);
    assign backoff_end = (retrydelay == 16'd0) || (cnt >= (32'(retrydelay) - 32'd1));
    assign cnt_inc     = (cnt == '1) ? cnt : cnt + 32'd1;

    always_comb begin
        launch_mask = '0;
        for (int i = 0; i < NSTEP; i++) begin
            launch_mask[i] = (i >= int'(sel));
        end
    end

    prio_hi_zero #(.N(NSTEP), .W(SW)) u_prio_hi_zero (
        .vec   (chain_done),
        .lo    (sel),
        .idx_c (fz_idx)
    );

`ifdef CHAINRESET_SEQ_AUTORESTART_EN
    logic done_q;

    // Previous done of the stop step, for falling-edge detection in SUCCESS.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            done_q <= 1'b0;
        end else begin
            done_q <= chain_done[sel];
        end
    end

    assign restart = linkdown || (done_q && !chain_done[sel]);
`else
    logic unused_linkdown;
    assign unused_linkdown = linkdown;
    assign restart         = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state         <= S_IDLE;
            cnt           <= '0;
            chain_resetin <= '0;
            busy          <= 1'b0;
            success       <= 1'b0;
            fail          <= 1'b0;
            donepulse     <= 1'b0;
            retrycnt      <= '0;
            failstep      <= '0;
        end else begin
            state         <= state_d;
            cnt           <= cnt_d;
            chain_resetin <= resetin_d;
            busy          <= busy_d;
            success       <= success_d;
            fail          <= fail_d;
            donepulse     <= donepulse_d;
            retrycnt      <= retrycnt_d;
            failstep      <= failstep_d;
        end
    end

    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        resetin_d   = chain_resetin;
        success_d   = success;
        fail_d      = fail;
        donepulse_d = 1'b0;
        retrycnt_d  = retrycnt;
        failstep_d  = failstep;

        if (abort) begin
            state_d   = S_IDLE;
            cnt_d     = '0;
            resetin_d = '0;
            success_d = 1'b0;
            fail_d    = 1'b0;
        end else begin
            case (state)
                S_IDLE, S_FAIL, S_SUCCESS: begin
                    if (start || ((state == S_SUCCESS) && restart)) begin
                        state_d    = S_ARM;
                        cnt_d      = '0;
                        resetin_d  = '0;
                        success_d  = 1'b0;
                        fail_d     = 1'b0;
                        retrycnt_d = '0;
                        if (start) begin
                            failstep_d = '0;
                        end
                    end
                end
                S_ARM: begin
                    resetin_d = '0;
                    if (cnt == 32'(ARMLEN - 1)) begin
                        state_d   = S_LAUNCH;
                        cnt_d     = '0;
                        resetin_d = launch_mask;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                S_LAUNCH: begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end
                S_WAIT: begin
                    // Status is blanked while the chain clears its sticky flags.
                    if ((cnt >= 32'(BLANK)) && done_hit) begin
                        state_d     = S_SUCCESS;
                        success_d   = 1'b1;
                        donepulse_d = 1'b1;
                    end else if ((cnt >= 32'(BLANK)) && (err_hit || timeout_hit)) begin
                        failstep_d = fz_idx;
                        resetin_d  = '0;
                        cnt_d      = '0;
                        if (retrycnt < maxretry) begin
                            state_d = S_BACKOFF;
                        end else begin
                            state_d = S_FAIL;
                            fail_d  = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                S_BACKOFF: begin
                    if (backoff_end) begin
                        state_d    = S_ARM;
                        cnt_d      = '0;
                        retrycnt_d = (retrycnt == 8'hFF) ? retrycnt : retrycnt + 8'd1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    state_d   = S_IDLE;
                    cnt_d     = '0;
                    resetin_d = '0;
                end
            endcase
        end

        busy_d = (state_d == S_ARM) || (state_d == S_LAUNCH) ||
                 (state_d == S_WAIT) || (state_d == S_BACKOFF);
    end

endmodule

// File: tb/tb_chainreset_seq.sv
// Bench for chainreset_seq: phase-level reference model compared every cycle,
// a simple timed chain model, and hand-computed expectations per scenario.
module tb_chainreset_seq;

    localparam int NSTEP    = 4;
    localparam int SW       = 2;
    localparam int ARMLEN   = 4;
    localparam int BLANK    = 2;
    localparam int STEP_CYC = 10;

`ifdef CHAINRESET_SEQ_AUTORESTART_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    localparam int P_IDLE = 0, P_ARM = 1, P_LAUNCH = 2, P_WAIT = 3,
                   P_BACK = 4, P_SUCC = 5, P_FAIL = 6;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [SW-1:0]    stopstep = '0;
    logic [7:0]       maxretry = '0;
    logic [15:0]      retrydelay = '0;
    logic [31:0]      gtimeout = '0;
    logic             linkdown = 1'b0;
    logic [NSTEP-1:0] chain_resetin;
    logic [NSTEP-1:0] chain_done = '0;
    logic [NSTEP-1:0] chain_error = '0;
    logic             busy, success, fail, donepulse;
    logic [7:0]       retrycnt;
    logic [SW-1:0]    failstep;

    int checks = 0;
    int errors = 0;
    int zero_busy_cnt = 0;
    int pulse_cnt = 0;

    int ch_t = 0;
    int err_step = -1;
    bit never_done = 1'b0;

    int               m_phase = P_IDLE;
    int               m_age = 0;
    int               m_retry = 0;
    int               m_fstep = 0;
    bit               m_pulse = 1'b0;
    bit               m_valid = 1'b0;
    bit               m_prev_done = 1'b0;
    logic [NSTEP-1:0] m_mask = '0;

    always #5 clk = ~clk;

    chainreset_seq #(.NSTEP(NSTEP), .SW(SW), .ARMLEN(ARMLEN), .BLANK(BLANK)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .start         (start),
        .abort         (abort),
        .stopstep      (stopstep),
        .maxretry      (maxretry),
        .retrydelay    (retrydelay),
        .gtimeout      (gtimeout),
        .linkdown      (linkdown),
        .chain_resetin (chain_resetin),
        .chain_done    (chain_done),
        .chain_error   (chain_error),
        .busy          (busy),
        .success       (success),
        .fail          (fail),
        .donepulse     (donepulse),
        .retrycnt      (retrycnt),
        .failstep      (failstep)
    );

    // Chain: top step restarts on resetin[NSTEP-1]; each enabled step finishes STEP_CYC later.
    always @(negedge clk) begin
        if (!chain_resetin[NSTEP-1]) begin
            ch_t        = 0;
            chain_done  = '0;
            chain_error = '0;
        end else begin
            ch_t++;
            if (!never_done) begin
                for (int i = NSTEP - 1; i >= 0; i--) begin
                    if (!chain_resetin[i] || (ch_t < STEP_CYC * (NSTEP - i))) break;
                    if (i == err_step) begin
                        chain_error[i] = 1'b1;
                        break;
                    end
                    chain_done[i] = 1'b1;
                end
            end
        end
    end

    // Reference model: phase plus age-in-phase, advanced on each rising edge.
    always @(posedge clk) begin
        int sel;
        bit err_any;
        int lim;
        sel = (int'(stopstep) > NSTEP - 1) ? NSTEP - 1 : int'(stopstep);
        m_pulse = 1'b0;
        if (!rstn) begin
            m_phase     = P_IDLE;
            m_age       = 0;
            m_retry     = 0;
            m_fstep     = 0;
            m_prev_done = 1'b0;
            m_mask      = '0;
            m_valid     = 1'b1;
        end else begin
            if (abort) begin
                m_phase = P_IDLE;
            end else if (start && (m_phase == P_IDLE || m_phase == P_SUCC || m_phase == P_FAIL)) begin
                m_phase = P_ARM; m_age = 0; m_retry = 0; m_fstep = 0;
            end else if (AUTO && m_phase == P_SUCC && (linkdown || (m_prev_done && !chain_done[sel]))) begin
                m_phase = P_ARM; m_age = 0; m_retry = 0;
            end else begin
                case (m_phase)
                    P_ARM: begin
                        m_age++;
                        if (m_age == ARMLEN) begin
                            m_phase = P_LAUNCH;
                            m_mask  = NSTEP'((1 << NSTEP) - (1 << sel));
                        end
                    end
                    P_LAUNCH: begin
                        m_phase = P_WAIT;
                        m_age   = 0;
                    end
                    P_WAIT: begin
                        err_any = 1'b0;
                        for (int i = sel; i < NSTEP; i++) err_any |= chain_error[i];
                        if (m_age >= BLANK && chain_done[sel]) begin
                            m_phase = P_SUCC;
                            m_pulse = 1'b1;
                        end else if (m_age >= BLANK &&
                                     (err_any || (gtimeout != 0 && m_age == int'(gtimeout)))) begin
                            for (int i = NSTEP - 1; i >= sel; i--) begin
                                if (!chain_done[i]) begin
                                    m_fstep = i;
                                    break;
                                end
                            end
                            m_age   = 0;
                            m_phase = (m_retry < int'(maxretry)) ? P_BACK : P_FAIL;
                        end else begin
                            m_age++;
                        end
                    end
                    P_BACK: begin
                        m_age++;
                        lim = (retrydelay == 0) ? 1 : int'(retrydelay);
                        if (m_age >= lim) begin
                            m_phase = P_ARM;
                            m_age   = 0;
                            if (m_retry < 255) m_retry++;
                        end
                    end
                    default: ;
                endcase
            end
            m_prev_done = chain_done[sel];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic compare_loop();
        logic [NSTEP-1:0] e_rst;
        forever begin
            @(negedge clk);
            if (m_valid) begin
                e_rst = (m_phase == P_LAUNCH || m_phase == P_WAIT || m_phase == P_SUCC) ? m_mask : '0;
                chk("model_resetin", 32'(chain_resetin), 32'(e_rst));
                chk("model_busy", 32'(busy), 32'(m_phase >= P_ARM && m_phase <= P_BACK));
                chk("model_success", 32'(success), 32'(m_phase == P_SUCC));
                chk("model_fail", 32'(fail), 32'(m_phase == P_FAIL));
                chk("model_donepulse", 32'(donepulse), 32'(m_pulse));
                chk("model_retrycnt", 32'(retrycnt), 32'(m_retry));
                chk("model_failstep", 32'(failstep), 32'(m_fstep));
            end
            if (busy && chain_resetin == '0) zero_busy_cnt++;
            if (donepulse) pulse_cnt++;
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic pulse_abort();
        abort = 1'b1;
        step(1);
        abort = 1'b0;
    endtask

    task automatic wait_success(input int lim);
        int n;
        n = 0;
        while (!success && n < lim) begin
            step(1);
            n++;
        end
    endtask

    task automatic wait_fail(input int lim);
        int n;
        n = 0;
        while (!fail && n < lim) begin
            step(1);
            n++;
        end
    endtask

    task automatic wait_launch(input int lim);
        int n;
        n = 0;
        while (chain_resetin == '0 && n < lim) begin
            step(1);
            n++;
        end
    endtask

    initial begin
        int z0, p0, n;
        fork
            compare_loop();
        join_none

        // Reset state
        step(3);
        chk("rst_resetin", 32'(chain_resetin), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_success", 32'(success), 32'd0);
        chk("rst_fail", 32'(fail), 32'd0);
        chk("rst_retrycnt", 32'(retrycnt), 32'd0);
        rstn = 1'b1;
        step(2);

        // 1: clean run, all four steps
        z0 = zero_busy_cnt; p0 = pulse_cnt;
        pulse_start();
        wait_success(200);
        chk("t1_success", 32'(success), 32'd1);
        chk("t1_arm_cycles", 32'(zero_busy_cnt - z0), 32'd4);
        chk("t1_resetin", 32'(chain_resetin), 32'hF);
        chk("t1_retrycnt", 32'(retrycnt), 32'd0);
        step(5);
        chk("t1_pulse_count", 32'(pulse_cnt - p0), 32'd1);

        // 2: step 2 errors every attempt, two retries of 20 cycles
        err_step = 2; maxretry = 8'd2; retrydelay = 16'd20;
        z0 = zero_busy_cnt;
        pulse_start();
        wait_fail(600);
        chk("t2_fail", 32'(fail), 32'd1);
        chk("t2_failstep", 32'(failstep), 32'd2);
        chk("t2_retrycnt", 32'(retrycnt), 32'd2);
        chk("t2_zero_cycles", 32'(zero_busy_cnt - z0), 32'd52);
        chk("t2_resetin", 32'(chain_resetin), 32'd0);

        // 3: global timeout, no retries
        err_step = -1; never_done = 1'b1; maxretry = 8'd0; gtimeout = 32'd100;
        pulse_start();
        wait_launch(20);
        n = 0;
        while (!fail && n < 300) begin
            step(1);
            n++;
        end
        chk("t3_timeout_latency", 32'(n), 32'd102);
        chk("t3_failstep", 32'(failstep), 32'd3);
        chk("t3_retrycnt", 32'(retrycnt), 32'd0);

        // 4: partial chain down to step 2
        pulse_abort();
        never_done = 1'b0; gtimeout = 32'd0; stopstep = 2'd2;
        pulse_start();
        wait_success(200);
        chk("t4_success", 32'(success), 32'd1);
        chk("t4_resetin", 32'(chain_resetin), 32'hC);
        chk("t4_failstep", 32'(failstep), 32'd0);

        // 5: abort with simultaneous start during WAIT
        stopstep = 2'd0;
        pulse_start();
        wait_launch(20);
        step(5);
        abort = 1'b1; start = 1'b1;
        step(1);
        abort = 1'b0; start = 1'b0;
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_resetin", 32'(chain_resetin), 32'd0);
        step(50);
        chk("t5_no_success", 32'(success), 32'd0);
        chk("t5_no_fail", 32'(fail), 32'd0);
        pulse_start();
        wait_success(200);
        chk("t5_rerun_success", 32'(success), 32'd1);

        // 6: linkdown pulse while in SUCCESS
        p0 = pulse_cnt;
        linkdown = 1'b1;
        step(1);
        linkdown = 1'b0;
        step(2);
`ifdef CHAINRESET_SEQ_AUTORESTART_EN
        chk("t6_restart_success", 32'(success), 32'd0);
        chk("t6_restart_busy", 32'(busy), 32'd1);
        wait_success(200);
        chk("t6_resuccess", 32'(success), 32'd1);
        chk("t6_pulse_again", 32'(pulse_cnt - p0), 32'd1);
`else
        chk("t6_hold_success", 32'(success), 32'd1);
        chk("t6_hold_busy", 32'(busy), 32'd0);
        step(50);
        chk("t6_no_pulse", 32'(pulse_cnt - p0), 32'd0);
`endif

        // 7: synchronous reset mid-run
        pulse_start();
        wait_launch(20);
        step(3);
        rstn = 1'b0;
        step(1);
        rstn = 1'b1;
        chk("t7_resetin", 32'(chain_resetin), 32'd0);
        chk("t7_busy", 32'(busy), 32'd0);
        step(60);
        chk("t7_idle", 32'(success | fail | busy), 32'd0);

        // 8: zero back-off delay means a one-cycle back-off
        err_step = 2; maxretry = 8'd1; retrydelay = 16'd0;
        z0 = zero_busy_cnt;
        pulse_start();
        wait_fail(300);
        chk("t8_fail", 32'(fail), 32'd1);
        chk("t8_retrycnt", 32'(retrycnt), 32'd1);
        chk("t8_zero_cycles", 32'(zero_busy_cnt - z0), 32'd9);
        step(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/chainreset_seq.md
Name: chainreset_seq

Overview:
- Top-level sequencer for the multi-step reset chain block.
- Takes software start/abort commands and drives the chain's per-step resetin vector, including the top-bit rising edge that restarts the chain.
- Monitors the chain's done/error vectors, applies a global timeout, retries the whole chain with a back-off delay, and reports which step failed.
- Sits between the register bank and the reset chain that brings up the DAC/ADC/clock steps.

Parameters:
NSTEP, 4, number of chain steps; must match the controlled chain.
SW, 2, width of step-index fields; needs 2**SW >= NSTEP.
ARMLEN, 4, cycles resetin is held low before launch; minimum 2.
BLANK, 2, WAIT cycles during which chain status is ignored while the chain clears sticky flags.

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
start  in  1  one-cycle launch request
abort  in  1  one-cycle abort request
stopstep  in  SW  lowest step to run; steps NSTEP-1 down to stopstep run
maxretry  in  8  retries allowed after the first attempt
retrydelay  in  16  back-off cycles between attempts
gtimeout  in  32  global WAIT timeout in cycles; 0 = disabled
linkdown  in  1  health-loss indication; used only with the optional feature
chain_resetin  out  NSTEP  to chain resetin
chain_done  in  NSTEP  from chain done
chain_error  in  NSTEP  from chain error
busy  out  1  high in ARM/LAUNCH/WAIT/BACKOFF
success  out  1  level, high in SUCCESS
fail  out  1  level, high in FAIL
donepulse  out  1  one cycle on entry to SUCCESS
retrycnt  out  8  retries used in the current run
failstep  out  SW  step blamed at the last error or timeout

Behaviour:
- Reset: rstn=0 sampled at a clk edge puts state in IDLE. All outputs are 0, all counters are 0.
- All outputs are registered.
- States are IDLE, ARM, LAUNCH, WAIT, BACKOFF, SUCCESS, FAIL.
- start is accepted in IDLE, SUCCESS and FAIL only; it is ignored while busy.
  - Acceptance clears retrycnt, failstep, success and fail.
  - Next state is ARM.
- abort is honoured in any state.
  - Next cycle: chain_resetin=0, state IDLE, success and fail cleared, retrycnt and failstep kept.
  - abort has priority over start in the same cycle.
- ARM: chain_resetin=0 for exactly ARMLEN cycles, then LAUNCH.
- LAUNCH: one cycle; chain_resetin[i]=1 for i>=stopstep and 0 for i<stopstep, then WAIT.
  - This pattern is held through WAIT and SUCCESS.
  - stopstep>NSTEP-1 saturates to NSTEP-1.
- WAIT: cnt starts at 0 on entry and counts up.
  - For the first BLANK cycles, chain_done and chain_error are ignored.
  - Then, in priority order:
    1. chain_done[stopstep]=1 -> SUCCESS.
    2. Any chain_error bit in [stopstep, NSTEP-1] -> attempt failed.
    3. gtimeout!=0 and cnt==gtimeout -> attempt failed.
  - Done wins over a simultaneous error.
- On a failed attempt:
  - failstep = highest index i in [stopstep, NSTEP-1] with chain_done[i]=0.
  - If retrycnt<maxretry: go to BACKOFF.
  - Else: go to FAIL.
- BACKOFF: chain_resetin=0 for retrydelay cycles (0 means exit after 1 cycle), then retrycnt+1, then ARM.
  - retrycnt saturates at 255.
- SUCCESS: success=1; donepulse=1 on the entry cycle only; chain_resetin held. Stays until start or abort.
- FAIL: fail=1; chain_resetin=0. Stays until start or abort.
- maxretry=0: the first failure goes straight to FAIL.
- rstn mid-run: returns to IDLE next cycle with chain_resetin=0; an attempt in progress is lost.

Optional Feature:
- Macro: CHAINRESET_SEQ_AUTORESTART_EN.
- Defined: in SUCCESS, linkdown=1 or a falling edge of chain_done[stopstep] triggers a restart.
  - Restart clears retrycnt and success and goes to ARM.
  - Same timing as a software start; donepulse fires again on the next success.
- Not defined: linkdown is ignored, and SUCCESS is left only via start, abort or rstn.

Decomposition:
- Package chainreset_seq_pkg holds:
  - state encoding localparams (3 bits);
  - default ARMLEN and BLANK;
  - function clog2 for SW checking.
- One sub-module, prio_hi_zero: a combinational highest-index-zero finder over NSTEP bits with a lower-bound input, used for failstep.

Test Plan:
1. NSTEP=4, stopstep=0, chain model completing each step in 10 cycles, start -> chain_resetin=4'b0000 for 4 cycles, then 4'b1111; success=1; donepulse exactly 1 cycle; retrycnt=0.
2. Step 2 raises error, maxretry=2, retrydelay=20 -> 2 back-offs of 20 cycles with chain_resetin=0; then fail=1, failstep=2, retrycnt=2.
3. gtimeout=100, chain never done, maxretry=0 -> fail asserts 100+BLANK-relative cycles after LAUNCH per count rule; failstep=3.
4. stopstep=2 -> chain_resetin=4'b1100; success on chain_done[2] while chain_done[1:0]=0.
5. abort during WAIT, start in the same cycle -> IDLE, chain_resetin=0, busy=0, no success/fail; a later start runs normally.
6. With macro, linkdown pulse in SUCCESS -> success drops; ARM/LAUNCH re-run; donepulse again. Without macro -> no change.
